// File: rtl/pktbuf_slot_alloc.sv
// Packet-buffer free-slot pool: self-seeding circular buffer with a show-ahead alloc stage.
// Optional double-free detection is enabled with the PKTBUF_FREE_CHECK_EN macro.
module pktbuf_slot_alloc #(
    parameter int    NUM_SLOTS = 2048,
    parameter int    AWIDTH    = $clog2(NUM_SLOTS),
    parameter string MEM_TYPE  = "M20K"
) (
    input  logic              Clk,
    input  logic              Rst_n,
    output logic [AWIDTH-1:0] alloc_data,
    output logic              alloc_valid,
    input  logic              alloc_ready,
    input  logic [AWIDTH-1:0] free_data,
    input  logic              free_valid,
    output logic              free_ready,
    output logic              init_done,
    output logic [AWIDTH:0]   free_count,
    output logic [31:0]       stats_alloc,
    output logic [31:0]       stats_free,
    output logic              err_dup_free
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [AWIDTH:0]   FULL     = (AWIDTH+1)'(NUM_SLOTS);
    localparam logic [AWIDTH-1:0] LAST_ID  = AWIDTH'(NUM_SLOTS - 1);

    state_t            state;
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH-1:0] rd_q;
    logic              out_valid;
    logic              alloc_hs;
    logic              free_hs;
    logic              free_wr;
    logic              dup_free;
    logic              rd_en;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_wd;
    logic [AWIDTH:0]   ram_count;
    logic [AWIDTH:0]   free_count_nxt;

    assign alloc_data  = rd_q;
    assign alloc_valid = out_valid;
    assign alloc_hs    = out_valid && alloc_ready;
    assign free_hs     = free_valid && free_ready;
    assign free_wr     = free_hs && !dup_free;

    // free_count includes the ID parked in the output stage; the rest sits in the RAM.
    assign ram_count = free_count - {{AWIDTH{1'b0}}, out_valid};
    assign rd_en     = (state == ST_RUN) && (ram_count != '0) && (!out_valid || alloc_hs);

    assign free_count_nxt = free_count + {{AWIDTH{1'b0}}, free_wr}
                                       - {{AWIDTH{1'b0}}, alloc_hs};

    assign mem_we = Rst_n && ((state == ST_INIT) || free_wr);
    assign mem_wd = (state == ST_INIT) ? wr_ptr : free_data;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state       <= ST_INIT;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            free_count  <= '0;
            out_valid   <= 1'b0;
            free_ready  <= 1'b0;
            init_done   <= 1'b0;
            stats_alloc <= '0;
            stats_free  <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    wr_ptr     <= wr_ptr + 1'b1;
                    free_count <= free_count + 1'b1;
                    if (wr_ptr == LAST_ID) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    if (free_wr) wr_ptr <= wr_ptr + 1'b1;
                    if (rd_en)   rd_ptr <= rd_ptr + 1'b1;
                    out_valid   <= rd_en || (out_valid && !alloc_hs);
                    free_count  <= free_count_nxt;
                    free_ready  <= (free_count_nxt < FULL);
                    stats_alloc <= stats_alloc + {31'd0, alloc_hs};
                    stats_free  <= stats_free + {31'd0, free_wr};
                end
            endcase
        end
    end

    // Pool RAM with a registered read port; rd_q doubles as the show-ahead output register.
    if (MEM_TYPE == "MLAB") begin : g_mlab
        (* ramstyle = "MLAB" *) logic [AWIDTH-1:0] mem [NUM_SLOTS];
        always_ff @(posedge Clk) begin
            if (mem_we) mem[wr_ptr] <= mem_wd;
            if (rd_en)  rd_q <= mem[rd_ptr];
        end
    end else begin : g_m20k
        (* ramstyle = "M20K" *) logic [AWIDTH-1:0] mem [NUM_SLOTS];
        always_ff @(posedge Clk) begin
            if (mem_we) mem[wr_ptr] <= mem_wd;
            if (rd_en)  rd_q <= mem[rd_ptr];
        end
    end

`ifdef PKTBUF_FREE_CHECK_EN
    logic [NUM_SLOTS-1:0] in_use;

    // Freeing the very ID being allocated this cycle is legal even though its bit is clear.
    assign dup_free = free_hs && !in_use[free_data] && !(alloc_hs && (rd_q == free_data));

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            in_use       <= '0;
            err_dup_free <= 1'b0;
        end else begin
            if (alloc_hs) in_use[rd_q]      <= 1'b1;
            if (free_hs)  in_use[free_data] <= 1'b0;
            if (dup_free) err_dup_free      <= 1'b1;
        end
    end
`else
    assign dup_free     = 1'b0;
    assign err_dup_free = 1'b0;
`endif

endmodule

// File: tb/tb_pktbuf_slot_alloc.sv
// Bench for pktbuf_slot_alloc (NUM_SLOTS=16): directed scenarios plus random traffic,
// checked by a negedge monitor against a queue model of the free pool.
module tb_pktbuf_slot_alloc;

    localparam int NS = 16;
    localparam int AW = 4;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic [AW-1:0] alloc_data;
    logic          alloc_valid;
    logic          alloc_ready = 1'b0;
    logic [AW-1:0] free_data = '0;
    logic          free_valid = 1'b0;
    logic          free_ready;
    logic          init_done;
    logic [AW:0]   free_count;
    logic [31:0]   stats_alloc;
    logic [31:0]   stats_free;
    logic          err_dup_free;

    int n_checks = 0;
    int n_errors = 0;

    // Model: exp_q is the free pool in allocation order; held_q are IDs handed out.
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] held_q[$];
    int            n_alloc;
    int            n_free;
    logic          dup_seen;
    int            wait_cnt;
    logic          mon_en = 1'b0;

    pktbuf_slot_alloc #(.NUM_SLOTS(NS)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .alloc_data(alloc_data), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .free_data(free_data), .free_valid(free_valid), .free_ready(free_ready),
        .init_done(init_done), .free_count(free_count),
        .stats_alloc(stats_alloc), .stats_free(stats_free), .err_dup_free(err_dup_free)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    // Monitor: compare state reflecting all earlier handshakes, then apply the
    // handshakes that the coming edge will complete.
    always @(negedge Clk) begin
        if (!mon_en) begin
            exp_q.delete();
            held_q.delete();
            for (int i = 0; i < NS; i++) exp_q.push_back(AW'(i));
            n_alloc  = 0;
            n_free   = 0;
            dup_seen = 1'b0;
            wait_cnt = 0;
        end else begin
            check("free_count", 32'(free_count), exp_q.size());
            check("free_ready", 32'(free_ready), 32'(exp_q.size() < NS));
            check("stats_alloc", stats_alloc, n_alloc);
            check("stats_free", stats_free, n_free);
            check("err_dup_free", 32'(err_dup_free), 32'(dup_seen));
            if (exp_q.size() == 0) check("valid_when_empty", 32'(alloc_valid), 0);
            if (exp_q.size() > 0 && !alloc_valid) wait_cnt++;
            else wait_cnt = 0;
            check("alloc_latency_ok", 32'(wait_cnt < 2), 1);
            if (alloc_valid && alloc_ready && exp_q.size() > 0) begin
                logic [AW-1:0] e;
                e = exp_q.pop_front();
                check("alloc_data", 32'(alloc_data), 32'(e));
                held_q.push_back(e);
                n_alloc++;
            end
            if (free_valid && free_ready) begin
                int idx;
                idx = -1;
                foreach (held_q[i]) if (idx < 0 && held_q[i] == free_data) idx = i;
                if (idx >= 0) begin
                    held_q.delete(idx);
                    exp_q.push_back(free_data);
                    n_free++;
                end else begin
`ifdef PKTBUF_FREE_CHECK_EN
                    dup_seen = 1'b1;
`else
                    exp_q.push_back(free_data);
                    n_free++;
`endif
                end
            end
        end
    end

    task automatic do_init();
        int cyc;
        mon_en      = 1'b0;
        Rst_n       = 1'b0;
        alloc_ready = 1'b0;
        free_valid  = 1'b0;
        cycle();
        check("rst_alloc_valid", 32'(alloc_valid), 0);
        check("rst_free_ready", 32'(free_ready), 0);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_free_count", 32'(free_count), 0);
        check("rst_stats_alloc", stats_alloc, 0);
        check("rst_stats_free", stats_free, 0);
        check("rst_err_dup_free", 32'(err_dup_free), 0);
        cycle();
        Rst_n = 1'b1;
        cyc = 0;
        while (!init_done && cyc < 100) begin
            cycle();
            cyc++;
        end
        check("init_cycles", cyc, NS);
        check("init_free_count", 32'(free_count), NS);
        mon_en = 1'b1;
    endtask

    // Drain all seeded IDs back-to-back: 16 allocations in 17 cycles then empty.
    task automatic drain_seeded();
        alloc_ready = 1'b1;
        repeat (NS + 1) cycle();
        check("drain_stats_alloc", stats_alloc, NS);
        check("drain_valid_low", 32'(alloc_valid), 0);
        alloc_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int bubbles;
        int c0;
        int s0;
        int sa0;
        int sf0;
        int guard;

        do_init();
        drain_seeded();

        // Empty pool: free ID 7 and watch it come back out.
        free_valid = 1'b1;
        free_data  = 4'd7;
        cycle();
        free_valid = 1'b0;
        lat = 0;
        while (!alloc_valid && lat < 4) begin
            cycle();
            lat++;
        end
        check("free_to_alloc_latency_ok", 32'(lat <= 2), 1);
        check("refill_alloc_data", 32'(alloc_data), 7);
        check("refill_free_count", 32'(free_count), 1);

        // Return every held ID so the pool is full.
        guard = 0;
        while (held_q.size() > 0 && guard < 40) begin
            free_valid = 1'b1;
            free_data  = held_q[0];
            cycle();
            guard++;
        end
        free_valid = 1'b0;
        check("full_free_count", 32'(free_count), NS);

        // Full pool back-pressures a free until one ID is allocated.
        free_valid = 1'b1;
        free_data  = exp_q[0];
        cycle();
        check("full_backpressure", 32'(free_ready), 0);
        cycle();
        check("full_backpressure_hold", 32'(free_ready), 0);
        check("full_count_hold", 32'(free_count), NS);
        alloc_ready = 1'b1;
        cycle();
        alloc_ready = 1'b0;
        check("after_alloc_ready", 32'(free_ready), 1);
        cycle();
        free_valid = 1'b0;
        check("after_free_count", 32'(free_count), NS);

        // Simultaneous alloc+free for 100 cycles.
        alloc_ready = 1'b1;
        cycle();
        c0  = free_count;
        sa0 = stats_alloc;
        sf0 = stats_free;
        bubbles = 0;
        for (int i = 0; i < 100; i++) begin
            free_valid = 1'b1;
            free_data  = held_q[0];
            if (!alloc_valid) bubbles++;
            cycle();
        end
        alloc_ready = 1'b0;
        free_valid  = 1'b0;
        check("steady_free_count", 32'(free_count), c0);
        check("steady_stats_alloc", stats_alloc - sa0, 100);
        check("steady_stats_free", stats_free - sf0, 100);
        check("steady_bubbles", bubbles, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            alloc_ready = ($urandom_range(0, 3) != 0);
            if (held_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                free_valid = 1'b1;
                free_data  = held_q[$urandom_range(0, held_q.size() - 1)];
            end else begin
                free_valid = 1'b0;
            end
            cycle();
        end
        free_valid = 1'b0;

        // Reset mid-traffic with at least 5 IDs outstanding.
        alloc_ready = 1'b1;
        guard = 0;
        while (held_q.size() < 5 && guard < 40) begin
            cycle();
            guard++;
        end
        check("outstanding_ge5", 32'(held_q.size() >= 5), 1);
        free_valid = 1'b1;
        free_data  = held_q[0];
        do_init();
        drain_seeded();

        // Double free of ID 3 after allocating 0..3 (pool now 12 free, 4 held).
        guard = 0;
        free_valid = 1'b1;
        free_data  = 4'd3;
        cycle();
        cycle();
        free_valid = 1'b0;
        // First free of 3 is legitimate; the second is the duplicate.
        do_init();
        alloc_ready = 1'b1;
        guard = 0;
        while (held_q.size() < 4 && guard < 20) begin
            cycle();
            guard++;
        end
        alloc_ready = 1'b0;
        free_valid  = 1'b1;
        free_data   = 4'd3;
        cycle();
        free_valid = 1'b0;
        cycle();
        c0 = free_count;
        s0 = stats_free;
        free_valid = 1'b1;
        free_data  = 4'd3;
        cycle();
        free_valid = 1'b0;
        cycle();
`ifdef PKTBUF_FREE_CHECK_EN
        check("dup_err_set", 32'(err_dup_free), 1);
        check("dup_count_same", 32'(free_count), c0);
        check("dup_stats_same", stats_free, s0);
`else
        check("dup_err_off", 32'(err_dup_free), 0);
        check("dup_count_inc", 32'(free_count), c0 + 1);
        check("dup_stats_inc", stats_free, s0 + 1);
`endif

        repeat (3) cycle();
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
